// File: rtl/flag_pkg.sv
// Flag bit positions and default sizing for the status-flag register.
package flag_pkg;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  localparam int DEF_NFLAGS = 4;
  localparam int DEF_DEPTH  = 4;

endpackage

// File: rtl/flag_lifo.sv
// Save/restore LIFO for flag words. The occupancy count is the stack pointer.
// A simultaneous push and pop cancel out, so neither is accepted and neither
// is reported as an error.
module flag_lifo
  import flag_pkg::*;
#(
  parameter  int WIDTH = DEF_NFLAGS,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int PTR_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [PTR_W-1:0] cnt,
  output logic             full,
  output logic             empty,
  output logic             pop_acc,
  output logic             push_err,
  output logic             pop_err
);

  // Storage is rounded up to a power of two so the index width matches the
  // array; entries at or above DEPTH are never written.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MEM_N = 1 << IDX_W;

  logic [WIDTH-1:0] r_mem [MEM_N];
  logic [PTR_W-1:0] r_cnt;
  logic [IDX_W-1:0] w_wr_idx;
  logic [IDX_W-1:0] w_rd_idx;
  logic             w_full;
  logic             w_empty;
  logic             w_push_acc;

  assign w_full     = (r_cnt == PTR_W'(DEPTH));
  assign w_empty    = (r_cnt == '0);
  assign w_push_acc = push & ~pop & ~w_full;
  assign pop_acc    = pop & ~push & ~w_empty;
  assign push_err   = push & ~pop & w_full;
  assign pop_err    = pop & ~push & w_empty;

  assign w_wr_idx = IDX_W'(r_cnt);
  assign w_rd_idx = IDX_W'(r_cnt - PTR_W'(1));

  assign dout  = r_mem[w_rd_idx];
  assign cnt   = r_cnt;
  assign full  = w_full;
  assign empty = w_empty;

  // Occupancy count: up on accepted push, down on accepted pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_push_acc) begin
      r_cnt <= r_cnt + PTR_W'(1);
    end else if (pop_acc) begin
      r_cnt <= r_cnt - PTR_W'(1);
    end
  end

  // Storage write; contents are not reset since they are dead once cnt is 0.
  always_ff @(posedge clk) begin
    if (w_push_acc) begin
      r_mem[w_wr_idx] <= din;
    end
  end

endmodule

// File: rtl/flag_stack_register.sv
// ALU status-flag register with masked update and a save/restore LIFO.
// Optional feature macro: FLAG_STICKY_EN adds the sticky accumulator output
// and its clr_sticky input.
module flag_stack_register
  import flag_pkg::*;
#(
  parameter  int NFLAGS = DEF_NFLAGS,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int PTR_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              update,
  input  logic [NFLAGS-1:0] upd_mask,
  input  logic [NFLAGS-1:0] flags_in,
  input  logic              push,
  input  logic              pop,
  input  logic              clr_err,
`ifdef FLAG_STICKY_EN
  input  logic              clr_sticky,
  output logic [NFLAGS-1:0] sticky,
`endif
  output logic [NFLAGS-1:0] flags,
  output logic [PTR_W-1:0]  depth_cnt,
  output logic              full,
  output logic              empty,
  output logic              stack_err
);

  logic [NFLAGS-1:0] r_flags;
  logic              r_stack_err;
  logic [NFLAGS-1:0] w_upd_flags;
  logic [NFLAGS-1:0] w_top;
  logic              w_pop_acc;
  logic              w_push_err;
  logic              w_pop_err;

  // The LIFO always saves the registered flags, i.e. the pre-update value.
  flag_lifo #(
    .WIDTH (NFLAGS),
    .DEPTH (DEPTH)
  ) u_lifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .din      (r_flags),
    .dout     (w_top),
    .cnt      (depth_cnt),
    .full     (full),
    .empty    (empty),
    .pop_acc  (w_pop_acc),
    .push_err (w_push_err),
    .pop_err  (w_pop_err)
  );

  assign w_upd_flags = (r_flags & ~upd_mask) | (flags_in & upd_mask);

  // Live flags: a restored word overrides any same-cycle update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags <= '0;
    end else if (w_pop_acc) begin
      r_flags <= w_top;
    end else if (update) begin
      r_flags <= w_upd_flags;
    end
  end

  // Sticky stack error; a new error wins over a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stack_err <= 1'b0;
    end else if (w_push_err | w_pop_err) begin
      r_stack_err <= 1'b1;
    end else if (clr_err) begin
      r_stack_err <= 1'b0;
    end
  end

`ifdef FLAG_STICKY_EN
  logic [NFLAGS-1:0] r_sticky;

  // Accumulate every flag bit written by an update that was not overridden.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sticky <= '0;
    end else if (clr_sticky) begin
      r_sticky <= '0;
    end else if (update & ~w_pop_acc) begin
      r_sticky <= r_sticky | (flags_in & upd_mask);
    end
  end

  assign sticky = r_sticky;
`endif

  assign flags     = r_flags;
  assign stack_err = r_stack_err;

endmodule

// File: tb/tb_flag_stack_register.sv
// Self-checking bench for flag_stack_register (NFLAGS=4, DEPTH=4).
module tb_flag_stack_register;

  localparam int NF    = 4;
  localparam int DEPTH = 4;
  localparam int PW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          update;
  logic [NF-1:0] upd_mask;
  logic [NF-1:0] flags_in;
  logic          push;
  logic          pop;
  logic          clr_err;
  logic [NF-1:0] flags;
  logic [PW-1:0] depth_cnt;
  logic          full;
  logic          empty;
  logic          stack_err;
`ifdef FLAG_STICKY_EN
  logic          clr_sticky;
  logic [NF-1:0] sticky;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [NF-1:0] m_flags;
  logic          m_err;
  logic [NF-1:0] m_q[$];
  logic [NF-1:0] m_sticky;

  logic [NF+PW+2:0] w_obs;
  assign w_obs = {flags, depth_cnt, full, empty, stack_err};

  flag_stack_register #(.NFLAGS(NF), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .update    (update),
    .upd_mask  (upd_mask),
    .flags_in  (flags_in),
    .push      (push),
    .pop       (pop),
    .clr_err   (clr_err),
`ifdef FLAG_STICKY_EN
    .clr_sticky(clr_sticky),
    .sticky    (sticky),
`endif
    .flags     (flags),
    .depth_cnt (depth_cnt),
    .full      (full),
    .empty     (empty),
    .stack_err (stack_err)
  );

  always #5 clk = ~clk;

  function automatic logic [NF+PW+2:0] exp_state();
    int n;
    n = m_q.size();
    return {m_flags, PW'(n), n == DEPTH, n == 0, m_err};
  endfunction

  task automatic model_reset();
    m_flags  = '0;
    m_err    = 1'b0;
    m_q      = {};
    m_sticky = '0;
  endtask

  // One clock with the given inputs; reference model advanced from the same inputs.
  task automatic step(input logic u, input logic [NF-1:0] m, input logic [NF-1:0] f,
                      input logic ps, input logic pp, input logic ce, input logic cs);
    logic popped;
    logic seterr;
    update = u; upd_mask = m; flags_in = f; push = ps; pop = pp; clr_err = ce;
`ifdef FLAG_STICKY_EN
    clr_sticky = cs;
`endif
    @(posedge clk);
    popped = 1'b0;
    seterr = 1'b0;
    if (ps && !pp) begin
      if (m_q.size() < DEPTH) m_q.push_back(m_flags);
      else seterr = 1'b1;
    end
    if (pp && !ps) begin
      if (m_q.size() > 0) begin
        m_flags = m_q.pop_back();
        popped  = 1'b1;
      end else begin
        seterr = 1'b1;
      end
    end
    if (!popped && u) m_flags = (m_flags & ~m) | (f & m);
    if (cs) m_sticky = '0;
    else if (u && !popped) m_sticky = m_sticky | (f & m);
    if (seterr) m_err = 1'b1;
    else if (ce) m_err = 1'b0;
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    update = 0; upd_mask = 0; flags_in = 0; push = 0; pop = 0; clr_err = 0;
`ifdef FLAG_STICKY_EN
    clr_sticky = 0;
`endif
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (w_obs !== {4'h0, 3'd0, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset: got %h want %h", w_obs, {4'h0, 3'd0, 1'b0, 1'b1, 1'b0});
    end
  endtask

  task automatic test_masked_update();
    do_reset();
    step(1, 4'b0101, 4'hF, 0, 0, 0, 0);
    n_tests++;
    if (flags !== 4'h5) begin
      n_fail++;
      $display("FAIL mask_update1: got %h want 5", flags);
    end
    step(1, 4'b1000, 4'h0, 0, 0, 0, 0);
    n_tests++;
    if (flags !== 4'h5) begin
      n_fail++;
      $display("FAIL mask_update2: got %h want 5", flags);
    end
    step(1, 4'b0000, 4'hA, 0, 0, 0, 0);
    n_tests++;
    if (w_obs !== exp_state()) begin
      n_fail++;
      $display("FAIL mask_zero: got %h want %h", w_obs, exp_state());
    end
  endtask

  task automatic test_nested();
    do_reset();
    step(1, 4'hF, 4'h3, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(1, 4'hF, 4'hC, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(1, 4'hF, 4'h0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    n_tests++;
    if (flags !== 4'hC || depth_cnt !== 3'd1) begin
      n_fail++;
      $display("FAIL nested_pop1: got flags=%h depth=%0d want C/1", flags, depth_cnt);
    end
    step(0, 0, 0, 0, 1, 0, 0);
    n_tests++;
    if (flags !== 4'h3 || depth_cnt !== 3'd0 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL nested_pop2: got flags=%h depth=%0d empty=%b want 3/0/1",
               flags, depth_cnt, empty);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    // push k saves the pre-update word k-1, then flags become k
    for (int k = 1; k <= 5; k++) step(1, 4'hF, NF'(k), 1, 0, 0, 0);
    n_tests++;
    if (full !== 1'b1 || depth_cnt !== 3'd4 || stack_err !== 1'b1 || flags !== 4'h5) begin
      n_fail++;
      $display("FAIL overflow: got full=%b depth=%0d err=%b flags=%h want 1/4/1/5",
               full, depth_cnt, stack_err, flags);
    end
    step(0, 0, 0, 0, 0, 1, 0);
    n_tests++;
    if (stack_err !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_err: got %b want 0", stack_err);
    end
    for (int k = 3; k >= 0; k--) begin
      step(0, 0, 0, 0, 1, 0, 0);
      n_tests++;
      if (flags !== NF'(k) || w_obs !== exp_state()) begin
        n_fail++;
        $display("FAIL lifo_order[%0d]: got %h want flags %h state %h", k, w_obs, k, exp_state());
      end
    end
  endtask

  task automatic test_underflow();
    do_reset();
    step(1, 4'hF, 4'h9, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    n_tests++;
    if (flags !== 4'h9 || stack_err !== 1'b1 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL underflow: got flags=%h err=%b want 9/1", flags, stack_err);
    end
    step(0, 0, 0, 0, 0, 1, 0);
    step(1, 4'hF, 4'h6, 0, 1, 0, 0);
    n_tests++;
    if (flags !== 4'h6 || stack_err !== 1'b1) begin
      n_fail++;
      $display("FAIL underflow_upd: got flags=%h err=%b want 6/1", flags, stack_err);
    end
    step(0, 0, 0, 0, 1, 1, 0);
    n_tests++;
    if (stack_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_set_priority: got %b want 1", stack_err);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    step(1, 4'hF, 4'h1, 1, 0, 0, 0);
    step(1, 4'hF, 4'h2, 1, 0, 0, 0);
    step(1, 4'hF, 4'hA, 1, 1, 0, 0);
    n_tests++;
    if (depth_cnt !== 3'd2 || flags !== 4'hA || stack_err !== 1'b0) begin
      n_fail++;
      $display("FAIL push_pop: got depth=%0d flags=%h err=%b want 2/A/0",
               depth_cnt, flags, stack_err);
    end
    step(1, 4'hF, 4'h5, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    n_tests++;
    if (flags !== 4'hA || depth_cnt !== 3'd2) begin
      n_fail++;
      $display("FAIL push_preupdate: got flags=%h depth=%0d want A/2", flags, depth_cnt);
    end
    do_reset();
    step(0, 0, 0, 1, 1, 0, 0);
    n_tests++;
    if (w_obs !== {4'h0, 3'd0, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL push_pop_empty: got %h want %h", w_obs, {4'h0, 3'd0, 1'b0, 1'b1, 1'b0});
    end
  endtask

  task automatic test_random();
    int errs;
    logic ps, pp;
    do_reset();
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      ps = ($urandom_range(0, 2) == 0);
      pp = ($urandom_range(0, 2) == 0);
      step($urandom_range(0, 1) == 1, NF'($urandom), NF'($urandom), ps, pp,
           $urandom_range(0, 7) == 0, 1'b0);
      n_tests++;
      if (w_obs !== exp_state()) begin
        n_fail++;
        errs++;
        if (errs < 10) $display("FAIL random[%0d]: got %h want %h", i, w_obs, exp_state());
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(0, 0, 0, 0, 1, 0, 0);
    step(1, 4'hF, 4'h7, 1, 0, 0, 0);
    step(1, 4'hF, 4'hB, 1, 0, 0, 0);
    step(1, 4'hF, 4'hE, 1, 0, 0, 0);
    n_tests++;
    if (depth_cnt !== 3'd3 || stack_err !== 1'b1 || flags !== 4'hE) begin
      n_fail++;
      $display("FAIL pre_reset: got depth=%0d err=%b flags=%h want 3/1/E",
               depth_cnt, stack_err, flags);
    end
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if (w_obs !== {4'h0, 3'd0, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset: got %h want %h", w_obs, {4'h0, 3'd0, 1'b0, 1'b1, 1'b0});
    end
    #1;
    reset = 1'b0;
    model_reset();
    idle();
  endtask

`ifdef FLAG_STICKY_EN
  task automatic test_sticky();
    do_reset();
    step(1, 4'hF, 4'h8, 0, 0, 0, 0);
    step(1, 4'hF, 4'h1, 0, 0, 0, 0);
    n_tests++;
    if (sticky !== 4'h9) begin
      n_fail++;
      $display("FAIL sticky_acc: got %h want 9", sticky);
    end
    step(1, 4'hF, 4'h2, 0, 0, 0, 1);
    n_tests++;
    if (sticky !== 4'h0) begin
      n_fail++;
      $display("FAIL sticky_clr: got %h want 0", sticky);
    end
    for (int i = 0; i < 100; i++) begin
      step($urandom_range(0, 1) == 1, NF'($urandom), NF'($urandom),
           $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, 1'b0,
           $urandom_range(0, 15) == 0);
      n_tests++;
      if (sticky !== m_sticky) begin
        n_fail++;
        $display("FAIL sticky_rand[%0d]: got %h want %h", i, sticky, m_sticky);
      end
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    update = 0; upd_mask = 0; flags_in = 0; push = 0; pop = 0; clr_err = 0;
`ifdef FLAG_STICKY_EN
    clr_sticky = 0;
`endif
    model_reset();
    test_reset();
    test_masked_update();
    test_nested();
    test_overflow();
    test_underflow();
    test_simultaneous();
    test_async_reset();
    test_random();
`ifdef FLAG_STICKY_EN
    test_sticky();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
